// File: rtl/branch_predictor_if.sv
// Fetch/execute bus between the pipeline and the branch predictor.
// The pipeline side is the master; the predictor is the slave.
interface branch_predictor_if;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        pr_taken;
  logic [12:0] pr_offs;
  logic        ex_br_valid;
  logic [63:0] ex_pc;
  logic        ex_pr_taken;
  logic        ex_br_cond;
  logic [12:0] ex_br_offs;
  logic        stall;
  logic        pr_miss;
  logic [63:0] br_addr;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output if_pc, if_instr, ex_br_valid, ex_pc, ex_pr_taken, ex_br_cond,
           ex_br_offs, stall,
    input  pr_taken, pr_offs, pr_miss, br_addr, br_cnt, miss_cnt
  );

  modport slave (
    input  if_pc, if_instr, ex_br_valid, ex_pc, ex_pr_taken, ex_br_cond,
           ex_br_offs, stall,
    output pr_taken, pr_offs, pr_miss, br_addr, br_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter BHT predictor: asynchronous lookup at fetch,
// misprediction detect, redirect address and training at execute.
module branch_predictor #(
  parameter int         BHT_IDX_W = 6,
  parameter logic [1:0] CNT_RST   = 2'b01
) (
  input logic               clk,
  input logic               clr_n,
  branch_predictor_if.slave bp
);

  localparam int         BHT_DEPTH  = 1 << BHT_IDX_W;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [1:0]           bht [BHT_DEPTH];
  logic [BHT_IDX_W-1:0] if_idx;
  logic [BHT_IDX_W-1:0] ex_idx;
  logic                 is_branch;
  logic                 train;
  logic [1:0]           ctr_cur;
  logic [1:0]           ctr_nxt;
  logic [63:0]          ex_offs_sext;
  logic [31:0]          br_cnt_q;
  logic [31:0]          miss_cnt_q;

  assign if_idx       = bp.if_pc[BHT_IDX_W+1:2];
  assign ex_idx       = bp.ex_pc[BHT_IDX_W+1:2];
  assign is_branch    = (bp.if_instr[6:0] == OPC_BRANCH);
  assign train        = bp.ex_br_valid & ~bp.stall;
  assign ex_offs_sext = {{51{bp.ex_br_offs[12]}}, bp.ex_br_offs};

  // Bits outside the index / immediate fields are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{bp.if_pc[63:BHT_IDX_W+2], bp.if_pc[1:0],
                         bp.if_instr[24:12]};

  // Fetch side: read is combinational, so a same-cycle write is not bypassed.
  assign bp.pr_offs  = {bp.if_instr[31], bp.if_instr[7], bp.if_instr[30:25],
                        bp.if_instr[11:8], 1'b0};
  assign bp.pr_taken = is_branch & bht[if_idx][1];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    ctr_cur = bht[ex_idx];
    ctr_nxt = ctr_cur;
    if (bp.ex_br_cond) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_comb begin
    bp.pr_miss = 1'b0;
    bp.br_addr = '0;
    if (bp.ex_br_valid) begin
      bp.pr_miss = (bp.ex_br_cond != bp.ex_pr_taken);
      bp.br_addr = bp.ex_br_cond ? (bp.ex_pc + ex_offs_sext)
                                 : (bp.ex_pc + 64'd4);
    end
  end

  // NOTE: the BHT is a flop array rather than a RAM because it needs both an
  // asynchronous read and a full asynchronous clear to CNT_RST.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_RST;
    end else if (train) begin
      // NOTE: non-blocking so every reader this cycle sees the pre-edge value.
      bht[ex_idx] <= ctr_nxt;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else if (train) begin
      br_cnt_q <= br_cnt_q + 32'd1;
      if (bp.pr_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign bp.br_cnt   = br_cnt_q;
  assign bp.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected values are queued when a step
// is driven and popped by check() when the outputs are sampled.
module tb_branch_predictor;

  logic clk = 1'b0;
  logic clr_n;
  branch_predictor_if bus ();

  branch_predictor dut (.clk(clk), .clr_n(clr_n), .bp(bus));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  bht_m [64];
  logic [31:0] br_m, miss_m;

  localparam logic [31:0] BEQ_P16  = 32'h0000_0863;  // beq, offset +16
  localparam logic [31:0] BEQ_M2   = 32'hFE00_0FE3;  // beq, offset -2
  localparam logic [31:0] ADD_LIKE = 32'hFE00_0FB3;  // opcode 0110011

  task automatic expect_val(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, no expectation queued", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (e.tag == tag && obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h (queued as %s)", tag, obs, e.val, e.tag);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'b01;
    br_m   = '0;
    miss_m = '0;
  endtask

  task automatic model_train(input logic [63:0] pc, input logic cond, input logic miss);
    logic [5:0] ix;
    ix = pc[7:2];
    if (cond && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'd1;
    if (!cond && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'd1;
    br_m++;
    if (miss) miss_m++;
  endtask

  function automatic logic model_pred(input logic [63:0] pc);
    logic [5:0] ix;
    ix = pc[7:2];
    return bht_m[ix][1];
  endfunction

  task automatic fetch(input logic [63:0] pc, input logic [31:0] instr);
    bus.if_pc    = pc;
    bus.if_instr = instr;
  endtask

  task automatic ex_drive(input logic v, input logic [63:0] pc, input logic prt,
                          input logic cond, input logic [12:0] offs, input logic stl);
    bus.ex_br_valid = v;
    bus.ex_pc       = pc;
    bus.ex_pr_taken = prt;
    bus.ex_br_cond  = cond;
    bus.ex_br_offs  = offs;
    bus.stall       = stl;
  endtask

  // One resolving EX branch: queue and check the combinational redirect,
  // clock it in, then check the counters against the model.
  task automatic resolve(input string name, input logic [63:0] pc, input logic prt,
                         input logic cond, input logic [12:0] offs,
                         input logic exp_miss, input logic [63:0] exp_addr);
    ex_drive(1'b1, pc, prt, cond, offs, 1'b0);
    expect_val({name, "_miss"}, {63'd0, exp_miss});
    expect_val({name, "_addr"}, exp_addr);
    #1;
    check({name, "_miss"}, {63'd0, bus.pr_miss});
    check({name, "_addr"}, bus.br_addr);
    tick();
    model_train(pc, cond, exp_miss);
    ex_drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    expect_val({name, "_brcnt"}, {32'd0, br_m});
    expect_val({name, "_misscnt"}, {32'd0, miss_m});
    #1;
    check({name, "_brcnt"}, {32'd0, bus.br_cnt});
    check({name, "_misscnt"}, {32'd0, bus.miss_cnt});
  endtask

  task automatic check_fetch(input string name, input logic [63:0] pc,
                             input logic [31:0] instr, input logic exp_taken,
                             input logic [12:0] exp_offs);
    fetch(pc, instr);
    expect_val({name, "_taken"}, {63'd0, exp_taken});
    expect_val({name, "_offs"}, {51'd0, exp_offs});
    #1;
    check({name, "_taken"}, {63'd0, bus.pr_taken});
    check({name, "_offs"}, {51'd0, bus.pr_offs});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clr_n = 1'b0;
    fetch('0, '0);
    ex_drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    #2;
    expect_val("rst_taken", 64'd0);
    expect_val("rst_offs", 64'd0);
    expect_val("rst_miss", 64'd0);
    expect_val("rst_addr", 64'd0);
    expect_val("rst_brcnt", 64'd0);
    expect_val("rst_misscnt", 64'd0);
    check("rst_taken", {63'd0, bus.pr_taken});
    check("rst_offs", {51'd0, bus.pr_offs});
    check("rst_miss", {63'd0, bus.pr_miss});
    check("rst_addr", bus.br_addr);
    check("rst_brcnt", {32'd0, bus.br_cnt});
    check("rst_misscnt", {32'd0, bus.miss_cnt});
    tick();
    tick();
    clr_n = 1'b1;
    tick();

    // Fresh entry is weakly not-taken.
    check_fetch("beq0", 64'h8000_0000, BEQ_P16, 1'b0, 13'h0010);

    // Train entry 0 taken: 01 -> 10 -> 11 -> 11, then one not-taken -> 10.
    resolve("tr1", 64'h8000_0000, 1'b0, 1'b1, 13'h0010, 1'b1, 64'h8000_0010);
    check_fetch("tr1_f", 64'h8000_0000, BEQ_P16, 1'b1, 13'h0010);
    resolve("tr2", 64'h8000_0000, 1'b1, 1'b1, 13'h0010, 1'b0, 64'h8000_0010);
    resolve("tr3", 64'h8000_0000, 1'b1, 1'b1, 13'h0010, 1'b0, 64'h8000_0010);
    expect_val("tr3_cnt3", 64'd3);
    #1;
    check("tr3_cnt3", {32'd0, bus.br_cnt});
    resolve("sat", 64'h8000_0000, 1'b1, 1'b0, 13'h0010, 1'b1, 64'h8000_0004);
    check_fetch("sat_f", 64'h8000_0000, BEQ_M2, model_pred(64'h8000_0000), 13'h1FFE);
    check_fetch("nonbr", 64'h8000_0000, ADD_LIKE, 1'b0, 13'h1FFE);

    // Backward taken branch missed, then not-taken outcomes (index aliases 0).
    resolve("back", 64'h8000_0100, 1'b0, 1'b1, 13'h1FF0, 1'b1, 64'h8000_00F0);
    resolve("nt_m", 64'h8000_0100, 1'b1, 1'b0, 13'h1FF0, 1'b1, 64'h8000_0104);
    resolve("nt_h", 64'h8000_0100, 1'b0, 1'b0, 13'h1FF0, 1'b0, 64'h8000_0104);
    check_fetch("alias_f", 64'h8000_0000, BEQ_P16, model_pred(64'h8000_0000), 13'h0010);

    // Stalled branch on entry 1 trains exactly once, when it advances.
    fetch(64'h8000_0204, BEQ_P16);
    ex_drive(1'b1, 64'h8000_0204, 1'b0, 1'b1, 13'h0010, 1'b1);
    for (int c = 0; c < 3; c++) begin
      expect_val("stl_miss", 64'd1);
      expect_val("stl_brcnt", {32'd0, br_m});
      expect_val("stl_taken", 64'd0);
      #1;
      check("stl_miss", {63'd0, bus.pr_miss});
      check("stl_brcnt", {32'd0, bus.br_cnt});
      check("stl_taken", {63'd0, bus.pr_taken});
      tick();
    end
    bus.stall = 1'b0;
    expect_val("stl_same_cycle", 64'd0);
    #1;
    check("stl_same_cycle", {63'd0, bus.pr_taken});
    tick();
    model_train(64'h8000_0204, 1'b1, 1'b1);
    ex_drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    expect_val("stl_next_taken", 64'd1);
    expect_val("stl_brcnt_once", {32'd0, br_m});
    expect_val("idle_addr", 64'd0);
    #1;
    check("stl_next_taken", {63'd0, bus.pr_taken});
    check("stl_brcnt_once", {32'd0, bus.br_cnt});
    check("idle_addr", bus.br_addr);
    tick();
    expect_val("idle_brcnt", {32'd0, br_m});
    check("idle_brcnt", {32'd0, bus.br_cnt});
    // A single decrement from 10 must fall to 01 if only one train happened.
    resolve("stl_dec", 64'h8000_0204, 1'b1, 1'b0, 13'h0010, 1'b1, 64'h8000_0208);
    check_fetch("stl_dec_f", 64'h8000_0204, BEQ_P16, 1'b0, 13'h0010);

    // Train entry 2 to taken, then reset mid-cycle clears everything at once.
    resolve("pre_rst", 64'h8000_0008, 1'b0, 1'b1, 13'h0010, 1'b1, 64'h8000_0018);
    check_fetch("pre_rst_f", 64'h8000_0008, BEQ_P16, 1'b1, 13'h0010);
    #2;
    clr_n = 1'b0;
    model_reset();
    expect_val("mid_brcnt", 64'd0);
    expect_val("mid_misscnt", 64'd0);
    expect_val("mid_taken", 64'd0);
    #1;
    check("mid_brcnt", {32'd0, bus.br_cnt});
    check("mid_misscnt", {32'd0, bus.miss_cnt});
    check("mid_taken", {63'd0, bus.pr_taken});
    tick();
    clr_n = 1'b1;
    tick();
    resolve("post_rst", 64'h8000_0008, 1'b0, 1'b1, 13'h0010, 1'b1, 64'h8000_0018);
    check_fetch("post_rst_f", 64'h8000_0008, BEQ_P16, 1'b1, 13'h0010);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations left unchecked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch side: looks up a 2-bit saturating-counter branch history table (BHT) for the conditional branch being fetched. Drives pr_taken/pr_offs into the PC register.
- Execute side: compares the resolved branch outcome with the prediction carried down the pipeline. Drives pr_miss/br_addr to redirect the PC, trains the BHT, and keeps branch and mispredict counts.

Parameters:
- BHT_IDX_W, 6, index width; BHT holds 2**BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
- CNT_RST, 2'b01, reset value of every BHT counter (weakly not-taken).

Ports:
- clk  in  1  clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- if_pc  in  64  PC of the instruction in fetch.
- if_instr  in  32  instruction word in fetch.
- pr_taken  out  1  predicted-taken for a fetched conditional branch.
- pr_offs  out  13  B-type byte offset of the fetched branch, two's complement.
- ex_br_valid  in  1  EX stage holds a valid conditional branch.
- ex_pc  in  64  PC of the EX branch.
- ex_pr_taken  in  1  prediction made for that branch at fetch.
- ex_br_cond  in  1  resolved outcome, 1 = taken.
- ex_br_offs  in  13  B-type offset of the EX branch.
- stall  in  1  pipeline stall; EX does not advance.
- pr_miss  out  1  misprediction, redirect required.
- br_addr  out  64  correct next PC on misprediction.
- br_cnt  out  32  resolved conditional branches since reset.
- miss_cnt  out  32  mispredictions since reset.

Behaviour:
- Reset (clr_n low, asynchronous):
  - All BHT entries set to CNT_RST.
  - br_cnt and miss_cnt set to 0.
  - pr_taken, pr_offs, pr_miss and br_addr are combinational. During reset they are 0 because the BHT reads 01 and counters are cleared.
- Branch detect: the fetched instruction is a branch when if_instr[6:0] == 7'b1100011.
- Offset: pr_offs = {if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0}.
  - pr_offs is driven regardless of branch detect.
  - The PC register sign-extends it to 64 bits.
- Prediction: pr_taken = is_branch & bht[idx(if_pc)][1].
  - The BHT read is asynchronous, giving zero-cycle latency within the fetch cycle.
  - If the fetched instruction is not a branch, pr_taken = 0.
- Miss detect: pr_miss = ex_br_valid & (ex_br_cond != ex_pr_taken). It is combinational and not gated by stall; the PC register ignores it while stalled.
- Redirect address:
  - br_addr = ex_pc + sext64(ex_br_offs) when ex_br_cond = 1.
  - br_addr = ex_pc + 4 when ex_br_cond = 0.
  - Addition is modulo 2^64.
  - br_addr is 0 when ex_br_valid = 0.
- BHT training, on the rising clock edge when ex_br_valid & !stall: entry idx(ex_pc) increments on taken and decrements on not-taken.
  - Saturates at 11 and 00.
  - Counter state sequence: 00 -> 01 -> 10 -> 11.
- Training happens exactly once per resolved branch. A stalled EX branch trains only in the cycle it advances.
- Same-index read and write in one cycle: fetch sees the old value, so there is no bypass. The new value is visible from the next cycle.
- Counters:
  - br_cnt increments on each training event.
  - miss_cnt increments on each training event with pr_miss = 1.
  - Both wrap modulo 2^32 with no saturation.
- Aliasing: distinct PCs with equal index share an entry. This is expected and not detected.
- Reset asserted mid-operation clears the BHT and counters immediately. The first cycle after release behaves as post-reset.

Test Plan:
- Reset then fetch BEQ at if_pc=0x80000000 with offset +16 (if_instr=0x00000863) -> pr_taken=0, pr_offs=13'h0010.
- Train entry for ex_pc=0x80000000 taken twice (ex_br_valid=1, ex_br_cond=1, stall=0) -> counter 01->10->11. Next fetch of the same PC gives pr_taken=1; a third taken train stays at 11. br_cnt=3.
- EX: ex_pc=0x80000100, ex_pr_taken=0, ex_br_cond=1, ex_br_offs=13'h1FF0 (-16) -> pr_miss=1, br_addr=0x800000F0. miss_cnt increments by 1 on the edge.
- EX: ex_pc=0x80000100, ex_pr_taken=1, ex_br_cond=0 -> pr_miss=1, br_addr=0x80000104. With ex_pr_taken=0 and the same outcome -> pr_miss=0.
- Hold ex_br_valid=1 with stall=1 for 3 cycles, then stall=0 -> BHT and br_cnt update only once. Same-cycle fetch of the same index returns the old counter.
- Assert clr_n=0 mid-stream with counters nonzero -> br_cnt=0, miss_cnt=0 and all entries 01, without waiting for a clock edge.
